// File: rtl/l1d_port_arbiter_pkg.sv
// Shared types for the L1D port arbiter: memory op encoding, FSM states and
// requester count, plus a small owner-to-one-hot helper.
package l1d_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_LOAD     = 2'd0,
    MEM_STORE    = 2'd1,
    MEM_AMO      = 2'd2,
    MEM_PREFETCH = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  localparam int NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/l1d_arb_grant.sv
// Fixed-priority grant (LSU over IFP) with a saturating starvation counter
// that hands the port to IFP after STARVE_LIMIT consecutive lost arbitrations.
module l1d_arb_grant
  import l1d_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q;
  logic [7:0] starve_d;
  logic       ifp_wins_s;

  always_comb begin
    grant_o    = 2'b00;
    starve_d   = starve_q;
    ifp_wins_s = req_valid_i[1] && (!req_valid_i[0] || (starve_q == LIMIT));
    if (en_i && ifp_wins_s) begin
      grant_o  = 2'b10;
      starve_d = 8'd0;
    end else if (en_i && req_valid_i[0]) begin
      grant_o = 2'b01;
      // Only a contested LSU win counts as a lost arbitration for IFP.
      if (req_valid_i[1] && (starve_q != LIMIT)) begin
        starve_d = starve_q + 8'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      grant_o  = 2'b00;
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/l1d_port_arbiter.sv
// Shares the single L1D request port between LSU (0) and IFP (1): one
// outstanding transaction, response routed back to its owner with its tag.
module l1d_port_arbiter
  import l1d_port_arbiter_pkg::*;
#(
  parameter int TAG_WIDTH    = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_N_in,
  input  logic                              cs_N_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  mem_op_e [NUM_REQ-1:0]             req_op_in,
  input  logic [NUM_REQ-1:0][63:0]          req_addr_in,
  input  logic [NUM_REQ-1:0][63:0]          req_data_in,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  input  logic                              l1d_ready_in,
  input  logic                              l1d_valid_in,
  input  logic [63:0]                       l1d_data_in,
  output logic                              l1d_valid_out,
  output mem_op_e                           l1d_op_out,
  output logic [63:0]                       l1d_addr_out,
  output logic [63:0]                       l1d_data_out,
  output logic [NUM_REQ-1:0]                resp_valid_out,
  output logic [63:0]                       resp_data_out,
  output logic [TAG_WIDTH-1:0]              resp_tag_out,
  output logic                              err_out
);

  arb_state_e           state_q, state_d;
  mem_op_e              op_q, op_d;
  logic [63:0]          addr_q, addr_d;
  logic [63:0]          data_q, data_d;
  logic [63:0]          rdata_q, rdata_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [TAG_WIDTH-1:0] rtag_q, rtag_d;
  logic                 owner_q, owner_d;
  logic                 err_q, err_d;
  logic                 grant_en_s;
  logic [NUM_REQ-1:0]   grant_s;

  // Grants are suppressed during reset so no handshake is shown that reset would discard.
  assign grant_en_s = rst_N_in && !cs_N_in && (state_q == IDLE);

  l1d_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk_i       (clk_in),
    .rst_n_i     (rst_N_in),
    .en_i        (grant_en_s),
    .req_valid_i (req_valid_in),
    .grant_o     (grant_s)
  );

  assign req_ready_out = grant_s;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    if (l1d_valid_in && (state_q != WAIT_RESP)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          owner_d = grant_s[1];
          op_d    = req_op_in[grant_s[1]];
          addr_d  = req_addr_in[grant_s[1]];
          data_d  = req_data_in[grant_s[1]];
          tag_d   = req_tag_in[grant_s[1]];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (l1d_ready_in) state_d = WAIT_RESP;
        else              state_d = ISSUE;
      end
      WAIT_RESP: begin
        // Response fields are captured separately so they hold across the next accept.
        if (l1d_valid_in) begin
          rdata_d = l1d_data_in;
          rtag_d  = tag_q;
          state_d = RESP;
        end else begin
          state_d = WAIT_RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q <= IDLE;
      op_q    <= MEM_LOAD;
      addr_q  <= 64'd0;
      data_q  <= 64'd0;
      tag_q   <= '0;
      owner_q <= 1'b0;
      rdata_q <= 64'd0;
      rtag_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
      err_q   <= err_d;
    end
  end

  assign l1d_valid_out  = (state_q == ISSUE);
  assign l1d_op_out     = op_q;
  assign l1d_addr_out   = addr_q;
  assign l1d_data_out   = data_q;
  assign resp_valid_out = (state_q == RESP) ? owner_onehot(owner_q) : 2'b00;
  assign resp_data_out  = rdata_q;
  assign resp_tag_out   = rtag_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_l1d_port_arbiter.sv
// Bench for l1d_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l1d_port_arbiter;
  import l1d_port_arbiter_pkg::*;

  localparam int TW    = 10;
  localparam int LIMIT = 4;

  logic                       clk_in = 1'b0;
  logic                       rst_N_in, cs_N_in;
  logic [1:0]                 req_valid_in;
  mem_op_e [1:0]              req_op_in;
  logic [1:0][63:0]           req_addr_in, req_data_in;
  logic [1:0][TW-1:0]         req_tag_in;
  logic [1:0]                 req_ready_out;
  logic                       l1d_ready_in, l1d_valid_in;
  logic [63:0]                l1d_data_in;
  logic                       l1d_valid_out;
  mem_op_e                    l1d_op_out;
  logic [63:0]                l1d_addr_out, l1d_data_out;
  logic [1:0]                 resp_valid_out;
  logic [63:0]                resp_data_out;
  logic [TW-1:0]              resp_tag_out;
  logic                       err_out;

  l1d_port_arbiter #(.TAG_WIDTH(TW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
    .req_valid_in(req_valid_in), .req_op_in(req_op_in), .req_addr_in(req_addr_in),
    .req_data_in(req_data_in), .req_tag_in(req_tag_in), .req_ready_out(req_ready_out),
    .l1d_ready_in(l1d_ready_in), .l1d_valid_in(l1d_valid_in), .l1d_data_in(l1d_data_in),
    .l1d_valid_out(l1d_valid_out), .l1d_op_out(l1d_op_out), .l1d_addr_out(l1d_addr_out),
    .l1d_data_out(l1d_data_out), .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .resp_tag_out(resp_tag_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;
  int auto_l1d = 0;   // 0: manual L1D, 1: always ready/immediate response, 2: random
  bit armed = 1'b0;

  // Transaction-level model: at most one transaction, tracked by its progress.
  bit            m_busy, m_sent, m_pulse, m_err, m_owner;
  int            m_starve;
  mem_op_e       m_op;
  logic [63:0]   m_addr, m_data, m_rdata;
  logic [TW-1:0] m_tag, m_rtag;

  // Snapshots of DUT outputs taken mid-cycle.
  logic [1:0]    s_ready, s_resp_valid;
  logic          s_l1d_valid, s_err;
  mem_op_e       s_op;
  logic [63:0]   s_addr, s_data, s_rdata;
  logic [TW-1:0] s_rtag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_ready();
    if (!rst_N_in || cs_N_in || m_busy) return 2'b00;
    if (req_valid_in[1] && (!req_valid_in[0] || m_starve == LIMIT)) return 2'b10;
    if (req_valid_in[0]) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_waiting();
    return m_busy && m_sent && !m_pulse;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_sent = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_owner = 1'b0;
    m_starve = 0; m_rdata = 64'd0; m_rtag = '0;
  endtask

  // One clock cycle: settle inputs, sample and compare at negedge, advance the model.
  task automatic step();
    logic [1:0] e_ready;
    bit idx;
    if (auto_l1d == 1) begin
      l1d_ready_in = 1'b1;
      l1d_valid_in = model_waiting();
      l1d_data_in  = {$urandom, $urandom};
    end else if (auto_l1d == 2) begin
      l1d_ready_in = ($urandom_range(0, 1) == 1);
      l1d_valid_in = model_waiting() && ($urandom_range(0, 2) == 0);
      l1d_data_in  = {$urandom, $urandom};
    end
    @(negedge clk_in);
    s_ready = req_ready_out; s_resp_valid = resp_valid_out; s_l1d_valid = l1d_valid_out;
    s_err = err_out; s_op = l1d_op_out; s_addr = l1d_addr_out; s_data = l1d_data_out;
    s_rdata = resp_data_out; s_rtag = resp_tag_out;
    e_ready = model_ready();
    if (armed) begin
      chk("req_ready", 64'(s_ready), 64'(e_ready));
      chk("l1d_valid", 64'(s_l1d_valid), 64'(m_busy && !m_sent));
      chk("resp_valid", 64'(s_resp_valid), m_pulse ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
      chk("resp_data", s_rdata, m_rdata);
      chk("resp_tag", 64'(s_rtag), 64'(m_rtag));
      chk("err", 64'(s_err), 64'(m_err));
      if (m_busy && !m_sent) begin
        chk("l1d_op", 64'(s_op), 64'(m_op));
        chk("l1d_addr", s_addr, m_addr);
        chk("l1d_data", s_data, m_data);
      end
    end
    if (!rst_N_in) begin
      model_reset();
    end else begin
      if (l1d_valid_in && !model_waiting()) m_err = 1'b1;
      if (m_busy) begin
        if (m_pulse) begin
          m_busy = 1'b0; m_pulse = 1'b0; m_sent = 1'b0;
        end else if (!m_sent) begin
          if (l1d_ready_in) m_sent = 1'b1;
        end else if (l1d_valid_in) begin
          m_pulse = 1'b1; m_rdata = l1d_data_in; m_rtag = m_tag;
        end
      end else if (e_ready != 2'b00) begin
        idx = e_ready[1];
        m_owner = idx; m_op = req_op_in[idx]; m_addr = req_addr_in[idx];
        m_data = req_data_in[idx]; m_tag = req_tag_in[idx]; m_busy = 1'b1;
        if (idx) m_starve = 0;
        else if (req_valid_in[1] && m_starve < LIMIT) m_starve++;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input int n);
    req_valid_in = 2'b00;
    auto_l1d = 1;
    for (int i = 0; i < n; i++) step();
    auto_l1d = 0;
    l1d_valid_in = 1'b0;
  endtask

  int grants[$];
  int exp_order[6] = '{1, 1, 1, 1, 2, 1};
  int ifp_resp;

  initial begin
    rst_N_in = 1'b0; cs_N_in = 1'b0; req_valid_in = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_op_in[i] = MEM_LOAD; req_addr_in[i] = 64'd0; req_data_in[i] = 64'd0; req_tag_in[i] = '0;
    end
    l1d_ready_in = 1'b0; l1d_valid_in = 1'b0; l1d_data_in = 64'd0;
    model_reset();
    #1;
    step();
    armed = 1'b1;
    step();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_l1d_valid", 64'(s_l1d_valid), 64'd0);
    chk("rst_resp_valid", 64'(s_resp_valid), 64'd0);
    chk("rst_resp_data", s_rdata, 64'd0);
    chk("rst_err", 64'(s_err), 64'd0);
    rst_N_in = 1'b1; req_valid_in = 2'b00;
    step();

    // Single LSU load with minimum latency.
    req_valid_in = 2'b01; req_op_in[0] = MEM_LOAD; req_addr_in[0] = 64'h1000; req_tag_in[0] = 10'd5;
    l1d_ready_in = 1'b1;
    step(); chk("t1_accept", 64'(s_ready), 64'd1);
    req_valid_in = 2'b00;
    step(); chk("t1_l1d_valid", 64'(s_l1d_valid), 64'd1); chk("t1_l1d_addr", s_addr, 64'h1000);
    l1d_valid_in = 1'b1; l1d_data_in = 64'hDEAD;
    step();
    l1d_valid_in = 1'b0;
    step(); chk("t1_resp_valid", 64'(s_resp_valid), 64'd1);
    chk("t1_resp_data", s_rdata, 64'hDEAD); chk("t1_resp_tag", 64'(s_rtag), 64'd5);
    step(); chk("t1_resp_gone", 64'(s_resp_valid), 64'd0);

    // Starvation guard: both requesters valid continuously.
    req_valid_in = 2'b11; req_tag_in[0] = 10'd3; req_tag_in[1] = 10'd7;
    req_addr_in[1] = 64'h8000; auto_l1d = 1; ifp_resp = 0;
    for (int i = 0; i < 40 && grants.size() < 6; i++) begin
      step();
      if (s_ready != 2'b00) grants.push_back(int'(s_ready));
      if (s_resp_valid == 2'b10) begin ifp_resp++; chk("t2_ifp_tag", 64'(s_rtag), 64'd7); end
    end
    chk("t2_grant_count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size() && i < 6; i++) chk("t2_grant_order", 64'(grants[i]), 64'(exp_order[i]));
    drain(4);
    chk("t2_ifp_resp_seen", 64'(ifp_resp), 64'd1);

    // L1D stalls the request for three cycles.
    req_valid_in = 2'b01; req_op_in[0] = MEM_STORE; req_addr_in[0] = 64'h2000;
    req_data_in[0] = 64'h1234; req_tag_in[0] = 10'd11; l1d_ready_in = 1'b0;
    step(); chk("t3_accept", 64'(s_ready), 64'd1);
    req_valid_in = 2'b00;
    for (int k = 0; k < 4; k++) begin
      l1d_ready_in = (k == 3);
      step();
      chk("t3_l1d_valid", 64'(s_l1d_valid), 64'd1);
      chk("t3_l1d_addr", s_addr, 64'h2000); chk("t3_l1d_data", s_data, 64'h1234);
      chk("t3_l1d_op", 64'(s_op), 64'(MEM_STORE));
    end
    l1d_ready_in = 1'b0;
    step(); chk("t3_single_accept", 64'(s_l1d_valid), 64'd0);
    l1d_valid_in = 1'b1; l1d_data_in = 64'hACED;
    step();
    l1d_valid_in = 1'b0;
    step(); chk("t3_resp_valid", 64'(s_resp_valid), 64'd1); chk("t3_resp_tag", 64'(s_rtag), 64'd11);
    step();

    // Spurious L1D response while idle.
    l1d_valid_in = 1'b1; l1d_data_in = 64'h5555;
    step(); chk("t4_err_before", 64'(s_err), 64'd0);
    l1d_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk("t4_err_sticky", 64'(s_err), 64'd1); chk("t4_no_resp", 64'(s_resp_valid), 64'd0);
    end

    // Chip select blocks grants until it drops.
    cs_N_in = 1'b1; req_valid_in = 2'b10; req_tag_in[1] = 10'd20;
    for (int k = 0; k < 3; k++) begin step(); chk("t5_blocked", 64'(s_ready), 64'd0); end
    cs_N_in = 1'b0;
    step(); chk("t5_grant_ifp", 64'(s_ready), 64'd2);
    drain(6);

    // Reset while waiting for the L1D response, response arrives after release.
    req_valid_in = 2'b01; req_tag_in[0] = 10'd9; l1d_ready_in = 1'b1;
    step(); chk("t6_accept", 64'(s_ready), 64'd1);
    req_valid_in = 2'b00;
    step();
    rst_N_in = 1'b0;
    step();
    rst_N_in = 1'b1; l1d_valid_in = 1'b1; l1d_data_in = 64'hBEEF;
    step(); chk("t6_err_cleared", 64'(s_err), 64'd0); chk("t6_no_resp", 64'(s_resp_valid), 64'd0);
    l1d_valid_in = 1'b0;
    step(); chk("t6_err_set", 64'(s_err), 64'd1); chk("t6_no_resp2", 64'(s_resp_valid), 64'd0);
    rst_N_in = 1'b0;
    step();
    rst_N_in = 1'b1;

    // Randomized traffic against the model.
    auto_l1d = 2;
    for (int c = 0; c < 3000; c++) begin
      req_valid_in = 2'($urandom_range(0, 3));
      cs_N_in  = ($urandom_range(0, 4) == 0);
      rst_N_in = !($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        req_op_in[i]   = mem_op_e'($urandom_range(0, 3));
        req_addr_in[i] = {$urandom, $urandom};
        req_data_in[i] = {$urandom, $urandom};
        req_tag_in[i]  = TW'($urandom);
      end
      step();
    end
    rst_N_in = 1'b1; cs_N_in = 1'b0;
    drain(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l1d_port_arbiter.md
Name: l1d_port_arbiter

Overview:
- Shares the single L1D request port between two requesters: requester 0 is load_store_unit (LSU), requester 1 is the instruction-fetch/prefetch path (IFP).
- Sits between those requesters and the L1D cache. Accepts one request at a time, drives the L1D valid/ready handshake, waits for the L1D response and routes it back to the owner with its tag.
- Fixed priority to LSU, with a starvation guard for IFP. One outstanding L1D transaction maximum.

Parameters:
- TAG_WIDTH, 10, width of requester transaction tags.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which IFP is granted over LSU (legal range 1..255).

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  reset, synchronous, active-low
- cs_N_in  in  1  chip select; high blocks new grants
- req_valid_in  in  [1:0]  request valid, index 0=LSU, 1=IFP
- req_op_in  in  2 x mem_op_e  memory op per requester
- req_addr_in  in  2 x 64  address per requester
- req_data_in  in  2 x 64  store data per requester
- req_tag_in  in  2 x TAG_WIDTH  transaction tag per requester
- req_ready_out  out  [1:0]  request accepted this cycle if valid
- l1d_ready_in  in  1  L1D accepts request
- l1d_valid_in  in  1  L1D response valid
- l1d_data_in  in  64  L1D response data
- l1d_valid_out  out  1  request to L1D valid
- l1d_op_out  out  mem_op_e  op to L1D
- l1d_addr_out  out  64  address to L1D
- l1d_data_out  out  64  data to L1D
- resp_valid_out  out  [1:0]  one-cycle response pulse to owner
- resp_data_out  out  64  response data (shared by both requesters)
- resp_tag_out  out  TAG_WIDTH  tag of the responded transaction
- err_out  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_N_in==0 at posedge):
  - state=IDLE; all outputs 0; starvation counter 0; err_out 0.
  - Any in-flight transaction is dropped and no response is emitted for it.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESP.
- IDLE:
  - Grant is combinational. If cs_N_in==1, no grant.
  - Otherwise IFP wins if req_valid_in[1] && (!req_valid_in[0] || starve_cnt==STARVE_LIMIT); else LSU wins if valid.
  - req_ready_out has a single bit high, only for the winner.
  - On handshake: latch op/addr/data/tag/owner and go to ISSUE.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each IDLE cycle where both requesters are valid, cs_N_in==0 and LSU wins.
  - Clears when IFP is granted.
  - Holds otherwise.
- ISSUE:
  - l1d_valid_out=1 with the latched fields, all stable.
  - Leaves for WAIT_RESP on the cycle l1d_ready_in==1.
- WAIT_RESP:
  - On l1d_valid_in==1, register l1d_data_in into resp_data_out and go to RESP.
- RESP:
  - resp_valid_out[owner]=1 for exactly one cycle, with resp_tag_out = latched tag.
  - Next state is IDLE.
  - resp_data_out/resp_tag_out hold their values until the next response. resp_valid_out is 0 outside RESP.
- Minimum latency, with the L1D ready and responding immediately:
  - accept at t, L1D handshake at t+1, response sampled at t+2, resp pulse at t+3, next accept at t+4.
- cs_N_in rising mid-transaction: the in-flight transaction completes normally; only new grants are blocked.
- l1d_valid_in==1 in any state other than WAIT_RESP: ignored and err_out set (sticky until reset).
- Requester valid held high while not granted: no effect. Requests are never dropped once accepted.
- Store ops also wait for the L1D response (acknowledgement) before RESP.

Decomposition:
- Package types: reuse mem_op_e; add arb_state_e (IDLE, ISSUE, WAIT_RESP, RESP) and localparam NUM_REQ=2.
- Sub-module: l1d_arb_grant, the combinational priority-plus-starvation grant logic with the starvation counter. It is kept separate so it can be unit-tested.

Test Plan:
- Single LSU load, addr 0x1000, tag 5; L1D ready immediately, responds data 0xDEAD next cycle -> l1d_addr_out=0x1000 at t+1; resp_valid_out=2'b01, resp_data_out=0xDEAD, tag 5 at t+3.
- Both requesters valid continuously, STARVE_LIMIT=4 -> grant order LSU,LSU,LSU,LSU,IFP,LSU...; IFP's response carries IFP tag 7.
- L1D holds l1d_ready_in low for 3 cycles -> l1d_valid_out and addr/data stable for all 4 cycles; single L1D acceptance.
- Spurious l1d_valid_in pulse in IDLE -> err_out goes high and stays high; no resp_valid_out pulse.
- cs_N_in=1 while IFP valid, then cs_N_in=0 -> req_ready_out stays 00 throughout; grant to IFP on the first cycle cs_N_in==0.
- rst_N_in low during WAIT_RESP, then L1D responds -> no resp_valid_out; err_out set if the response arrives after reset releases (IDLE).
